// File: rtl/dnn_argmax_out.sv
// dnn_argmax_out
//   Classification stage placed after the DNN top. It collects the final
//   layer's output beats (NumIn scores per beat) until a done marker arrives.
//   Each captured beat is scanned one lane per cycle to track the running
//   maximum score and its class index (beat*NumIn + lane). The result is
//   presented on a valid/ready port and held until it is accepted.
//
//   Optional feature macro: ARGMAX_SIGNED_EN
//     defined   -> scores are compared as two's-complement signed values
//     undefined -> scores are compared as unsigned values
//
// Ports
//   clk        clock
//   res_n      asynchronous active-low reset
//   in_valid   in_data beat valid
//   in_done    end of frame (with the last beat or on its own)
//   in_data    NumIn packed scores, lane k at [k]
//   in_ready   a beat or done can be accepted this cycle
//   out_ready  downstream accepts the result
//   out_valid  result valid
//   out_class  index of the maximum score
//   out_max    maximum score
//   out_none   the frame held no valid beats
//   out_ovf    the frame held more than MaxBeats beats
//   out_drop   sticky: input asserted while in_ready was low
module dnn_argmax_out #(
  parameter int BitSize  = 8,
  parameter int NumIn    = 2,
  parameter int MaxBeats = 4,
  parameter int IdxW     = ((NumIn * MaxBeats) > 1) ? $clog2(NumIn * MaxBeats) : 1
) (
  input  logic                            clk,
  input  logic                            res_n,
  input  logic                            in_valid,
  input  logic                            in_done,
  input  logic [NumIn-1:0][BitSize-1:0]   in_data,
  output logic                            in_ready,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [IdxW-1:0]                 out_class,
  output logic [BitSize-1:0]              out_max,
  output logic                            out_none,
  output logic                            out_ovf,
  output logic                            out_drop
);

  localparam int LaneW = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int CntW  = $clog2(MaxBeats + 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    RESULT  = 2'd2
  } state_t;

  state_t                        state_reg;
  logic [NumIn-1:0][BitSize-1:0] beat_reg;
  logic                          done_reg;
  logic [LaneW-1:0]              lane_reg;
  logic [CntW-1:0]               beat_cnt_reg;
  logic [BitSize-1:0]            max_reg;
  logic [IdxW-1:0]               idx_reg;
  logic                          seen_reg;
  logic                          ovf_reg;

  logic                          in_ready_reg;
  logic                          out_valid_reg;
  logic [IdxW-1:0]               out_class_reg;
  logic [BitSize-1:0]            out_max_reg;
  logic                          out_none_reg;
  logic                          out_ovf_reg;
  logic                          out_drop_reg;

  logic [BitSize-1:0]            score;
  logic                          greater;
  logic                          take;
  logic [IdxW-1:0]               cur_idx;
  logic [BitSize-1:0]            max_next;
  logic [IdxW-1:0]               idx_next;

  // Compare path for the lane currently being scanned.
  always_comb begin
    score = beat_reg[lane_reg];
`ifdef ARGMAX_SIGNED_EN
    greater = $signed(score) > $signed(max_reg);
`else
    greater = score > max_reg;
`endif
    // The first score of a frame always loads; afterwards strictly greater
    // only, so ties keep the lower (earlier) index.
    take     = !seen_reg || greater;
    cur_idx  = IdxW'(32'(beat_cnt_reg) * 32'(NumIn) + 32'(lane_reg));
    max_next = take ? score : max_reg;
    idx_next = take ? cur_idx : idx_reg;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_reg     <= COLLECT;
      beat_reg      <= '0;
      done_reg      <= 1'b0;
      lane_reg      <= '0;
      beat_cnt_reg  <= '0;
      max_reg       <= '0;
      idx_reg       <= '0;
      seen_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_class_reg <= '0;
      out_max_reg   <= '0;
      out_none_reg  <= 1'b0;
      out_ovf_reg   <= 1'b0;
      out_drop_reg  <= 1'b0;
    end else begin
      // Anything offered while not ready is ignored but remembered.
      if ((in_valid || in_done) && !in_ready_reg) begin
        out_drop_reg <= 1'b1;
      end

      case (state_reg)
        COLLECT: begin
          if (in_valid) begin
            if (beat_cnt_reg < CntW'(MaxBeats)) begin
              beat_reg     <= in_data;
              done_reg     <= in_done;
              lane_reg     <= '0;
              state_reg    <= SCAN;
              in_ready_reg <= 1'b0;
            end else begin
              // Beat beyond capacity: data discarded, frame flagged.
              ovf_reg <= 1'b1;
              if (in_done) begin
                state_reg     <= RESULT;
                in_ready_reg  <= 1'b0;
                out_valid_reg <= 1'b1;
                out_class_reg <= idx_reg;
                out_max_reg   <= max_reg;
                out_none_reg  <= !seen_reg;
                out_ovf_reg   <= 1'b1;
              end
            end
          end else if (in_done) begin
            state_reg     <= RESULT;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b1;
            out_class_reg <= idx_reg;
            out_max_reg   <= max_reg;
            out_none_reg  <= !seen_reg;
            out_ovf_reg   <= ovf_reg;
          end
        end

        SCAN: begin
          max_reg  <= max_next;
          idx_reg  <= idx_next;
          seen_reg <= 1'b1;
          if (lane_reg == LaneW'(NumIn - 1)) begin
            lane_reg     <= '0;
            beat_cnt_reg <= beat_cnt_reg + CntW'(1);
            if (done_reg) begin
              // Result takes the values from this final compare directly.
              state_reg     <= RESULT;
              out_valid_reg <= 1'b1;
              out_class_reg <= idx_next;
              out_max_reg   <= max_next;
              out_none_reg  <= 1'b0;
              out_ovf_reg   <= ovf_reg;
            end else begin
              state_reg    <= COLLECT;
              in_ready_reg <= 1'b1;
            end
          end else begin
            lane_reg <= lane_reg + LaneW'(1);
          end
        end

        RESULT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            beat_cnt_reg  <= '0;
            max_reg       <= '0;
            idx_reg       <= '0;
            seen_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            done_reg      <= 1'b0;
            state_reg     <= COLLECT;
            in_ready_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg    <= COLLECT;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_class = out_class_reg;
  assign out_max   = out_max_reg;
  assign out_none  = out_none_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_drop  = out_drop_reg;

endmodule

// File: tb/tb_dnn_argmax_out.sv
// tb_dnn_argmax_out
//   Directed vectors with hand-computed expectations for dnn_argmax_out
//   (NumIn=2, BitSize=8, MaxBeats=4). Inputs are driven and outputs sampled
//   1 time unit after the rising edge.
module tb_dnn_argmax_out;

  logic             clk;
  logic             res_n;
  logic             in_valid;
  logic             in_done;
  logic [1:0][7:0]  in_data;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic [2:0]       out_class;
  logic [7:0]       out_max;
  logic             out_none;
  logic             out_ovf;
  logic             out_drop;

  int vec_cnt;
  int err_cnt;

  dnn_argmax_out #(
    .BitSize  (8),
    .NumIn    (2),
    .MaxBeats (4)
  ) dut (
    .clk       (clk),
    .res_n     (res_n),
    .in_valid  (in_valid),
    .in_done   (in_done),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_class (out_class),
    .out_max   (out_max),
    .out_none  (out_none),
    .out_ovf   (out_ovf),
    .out_drop  (out_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present one beat for one edge.
  task automatic send_beat(input logic [7:0] l0, input logic [7:0] l1, input logic done);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    in_data  = {l1, l0};
    in_valid = 1'b1;
    in_done  = done;
    tick();
    in_valid = 1'b0;
    in_done  = 1'b0;
    in_data  = '0;
  endtask

  // Wait (bounded) for out_valid, check the result, accept it.
  task automatic take_result(input string tag, input logic [2:0] cls, input logic [7:0] mx,
                             input logic none, input logic ovf, input logic drop);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_class"}, 32'(out_class), 32'(cls));
    check({tag, "_max"},   32'(out_max),   32'(mx));
    check({tag, "_none"},  32'(out_none),  32'(none));
    check({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
    check({tag, "_drop"},  32'(out_drop),  32'(drop));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_vclr"},  32'(out_valid), 32'd0);
    check({tag, "_rdy"},   32'(in_ready),  32'd1);
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    res_n     = 1'b0;
    in_valid  = 1'b0;
    in_done   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);
    check("rst_class", 32'(out_class), 32'd0);
    check("rst_max",   32'(out_max),   32'd0);
    check("rst_flags", {29'd0, out_none, out_ovf, out_drop}, 32'd0);
    res_n = 1'b1;
    tick();

    // Single beat with done: exact latency and hold while out_ready=0.
    send_beat(8'h03, 8'h05, 1'b1);
    check("t1_lat0_valid", 32'(out_valid), 32'd0);
    check("t1_lat0_ready", 32'(in_ready),  32'd0);
    tick();
    check("t1_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    check("t1_lat2_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("t1_hold_valid", 32'(out_valid), 32'd1);
      check("t1_hold_class", 32'(out_class), 32'd1);
      check("t1_hold_max",   32'(out_max),   32'h05);
      check("t1_hold_ready", 32'(in_ready),  32'd0);
      tick();
    end
    take_result("t1", 3'd1, 8'h05, 1'b0, 1'b0, 1'b0);

    // Two beats, stray in_valid during the first beat's scan.
    send_beat(8'd10, 8'd20, 1'b0);
    in_valid = 1'b1;
    in_data  = {8'hFF, 8'hFF};
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    check("t2_drop_set", 32'(out_drop), 32'd1);
    send_beat(8'd30, 8'd7, 1'b1);
    take_result("t2", 3'd2, 8'd30, 1'b0, 1'b0, 1'b1);

    // Tie: lower index wins.
    send_beat(8'h09, 8'h09, 1'b1);
    take_result("t3", 3'd0, 8'h09, 1'b0, 1'b0, 1'b1);

    // Done-only frame: valid right after the accepting edge.
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
    check("t3n_lat_valid", 32'(out_valid), 32'd1);
    take_result("t3n", 3'd0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Signedness check.
    send_beat(8'h7F, 8'h80, 1'b1);
`ifdef ARGMAX_SIGNED_EN
    take_result("t4", 3'd0, 8'h7F, 1'b0, 1'b0, 1'b1);
`else
    take_result("t4", 3'd1, 8'h80, 1'b0, 1'b0, 1'b1);
`endif

    // Overflow: fifth beat discarded, done on it ends the frame.
    for (int b = 0; b < 4; b++) send_beat(8'd1, 8'd1, 1'b0);
    send_beat(8'h50, 8'd1, 1'b1);
    take_result("t5", 3'd0, 8'd1, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a scan.
    send_beat(8'd1, 8'd2, 1'b0);
    res_n = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_ready", 32'(in_ready),  32'd1);
    check("t6_class", 32'(out_class), 32'd0);
    check("t6_max",   32'(out_max),   32'd0);
    check("t6_flags", {29'd0, out_none, out_ovf, out_drop}, 32'd0);
    #2;
    res_n = 1'b1;
    tick();
    send_beat(8'd4, 8'd3, 1'b1);
    take_result("t6b", 3'd0, 8'd4, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Absolute backstop against a hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
